// File: rtl/cv32e40s_instr_obi_adapter_if.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40s_instr_obi_adapter_if
// Description : Prefetcher transaction handshake plus OBI instruction bus.
// Revision    : 1.0
// ============================================================================
interface cv32e40s_instr_obi_adapter_if;
  logic        trans_valid_i;
  logic        trans_ready_o;
  logic [31:0] trans_addr_i;
  logic        instr_req_o;
  logic        instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [2:0]  outstanding_o;
  logic        busy_o;
  logic        protocol_err_o;

  // Adapter side
  modport slave (
    input  trans_valid_i, trans_addr_i, instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
    output trans_ready_o, instr_req_o, instr_addr_o, resp_valid_o, resp_rdata_o, resp_err_o,
           outstanding_o, busy_o, protocol_err_o
  );

  // Prefetcher / bus environment side
  modport master (
    output trans_valid_i, trans_addr_i, instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
    input  trans_ready_o, instr_req_o, instr_addr_o, resp_valid_o, resp_rdata_o, resp_err_o,
           outstanding_o, busy_o, protocol_err_o
  );
endinterface
`default_nettype wire

// File: rtl/cv32e40s_instr_obi_adapter.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40s_instr_obi_adapter
// Description : Prefetch handshake to OBI instruction port with address-phase
//               hold and outstanding limit. Optional checker macro:
//               CV32E40S_INSTR_OBI_PROTOCOL_CHK_EN
// Revision    : 1.0
// ============================================================================
module cv32e40s_instr_obi_adapter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  cv32e40s_instr_obi_adapter_if.slave   bus
);

  localparam logic [2:0] c_max = 3'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {
    TRANSPARENT = 1'b0,
    REGISTERED  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_addr_q;
  logic [2:0]  r_outstanding;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_capture;
  logic        w_accept;
  logic        w_retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= TRANSPARENT;
      r_addr_q <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_addr_q <= bus.trans_addr_i;
      end
    end
  end

  // Gating uses only the registered count, so rvalid never reaches req combinationally.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_addr      = bus.trans_addr_i;
    w_capture   = 1'b0;
    case (r_state)
      TRANSPARENT: begin
        w_req = bus.trans_valid_i && (r_outstanding < c_max);
        if (w_req && !bus.instr_gnt_i) begin
          w_state_nxt = REGISTERED;
          w_capture   = 1'b1;
        end
      end
      REGISTERED: begin
        w_req  = 1'b1;
        w_addr = r_addr_q;
        if (bus.instr_gnt_i) begin
          w_state_nxt = TRANSPARENT;
        end
      end
      default: begin
        w_state_nxt = TRANSPARENT;
      end
    endcase
  end

  assign w_accept = w_req && bus.instr_gnt_i;
  assign w_retire = bus.instr_rvalid_i && (r_outstanding != 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outstanding <= 3'd0;
    end else if (w_accept && !w_retire) begin
      r_outstanding <= r_outstanding + 3'd1;
    end else if (!w_accept && w_retire) begin
      r_outstanding <= r_outstanding - 3'd1;
    end
  end

  // Every output is forced low while reset is asserted.
  assign bus.instr_req_o   = w_req && !rst;
  assign bus.instr_addr_o  = rst ? 32'h0 : w_addr;
  assign bus.trans_ready_o = w_accept && !rst;
  assign bus.resp_valid_o  = bus.instr_rvalid_i && !rst;
  assign bus.resp_rdata_o  = rst ? 32'h0 : bus.instr_rdata_i;
  assign bus.resp_err_o    = bus.instr_err_i && !rst;
  assign bus.outstanding_o = rst ? 3'd0 : r_outstanding;
  assign bus.busy_o        = !rst && ((r_outstanding != 3'd0) || w_req);

`ifdef CV32E40S_INSTR_OBI_PROTOCOL_CHK_EN
  logic r_protocol_err;
  logic w_violation;

  assign w_violation = (bus.instr_rvalid_i && (r_outstanding == 3'd0)) ||
                       (bus.instr_gnt_i && !w_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_protocol_err <= 1'b0;
    end else if (w_violation) begin
      r_protocol_err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && w_violation) begin
      $error("cv32e40s_instr_obi_adapter: OBI protocol violation");
    end
  end
`endif

  assign bus.protocol_err_o = r_protocol_err && !rst;
`else
  assign bus.protocol_err_o = 1'b0;
`endif

endmodule
`default_nettype wire
